pipe_stall_ctrl: RTL and testbench

//  Consumer side of the pipeline stall/flush interface: takes stall/flush requests (load-use/Mfc0 stall

---
 rtl/pipe_stall_ctrl_pkg.sv | 28 ++
 rtl/pipe_stall_ctrl_if.sv | 31 +++
 rtl/pipe_stall_ctrl_wdog.sv | 35 +++
 rtl/pipe_stall_ctrl.sv | 109 ++++++++++
 tb/tb_pipe_stall_ctrl.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
// Control vector bit order: {pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush}.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        MDU_WAIT  = 2'd1,
        EXC_DRAIN = 2'd2
    } state_t;

    localparam int CNT_W = 32;

    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic if_id_flush;
        logic id_ex_flush;
        logic ex_mem_flush;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE   = 5'b11000;
    localparam ctrl_t CTRL_RST    = 5'b00111;
    localparam ctrl_t CTRL_STALL  = 5'b00010;
    localparam ctrl_t CTRL_BRANCH = 5'b11100;
    localparam ctrl_t CTRL_EXC    = 5'b11111;
    localparam ctrl_t CTRL_DRAIN  = 5'b11010;

endpackage

// File: rtl/pipe_stall_ctrl_if.sv
// Stall/flush request and pipeline-control bundle between hazard sources and the controller.
interface pipe_stall_ctrl_if;
    import pipe_ctrl_pkg::*;

    logic             lu_stall_req;
    logic             mdu_use;
    logic             mdu_busy;
    logic             branch_taken;
    logic             exc_req;
    logic             pc_write;
    logic             if_id_write;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic             ex_mem_flush;
    logic             wdog_err;
    logic [CNT_W-1:0] lu_stall_cnt;
    logic [CNT_W-1:0] mdu_stall_cnt;

    modport master (
        output lu_stall_req, mdu_use, mdu_busy, branch_taken, exc_req,
        input  pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush,
        input  wdog_err, lu_stall_cnt, mdu_stall_cnt
    );

    modport slave (
        input  lu_stall_req, mdu_use, mdu_busy, branch_taken, exc_req,
        output pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush,
        output wdog_err, lu_stall_cnt, mdu_stall_cnt
    );

endinterface

// File: rtl/pipe_stall_ctrl_wdog.sv
// Stall watchdog: counts consecutive stalled cycles, saturates at WDOG_LIMIT,
// and latches a sticky error once the limit is reached.
module stall_wdog #(
    parameter int WDOG_W     = 8,
    parameter int WDOG_LIMIT = 200
) (
    input  logic clock,
    input  logic reset,
    input  logic stall,
    output logic wdog_err
);

    localparam logic [WDOG_W-1:0] LIMIT   = WDOG_W'(WDOG_LIMIT);
    localparam logic [WDOG_W-1:0] LIMIT_M = WDOG_W'(WDOG_LIMIT - 1);

    logic [WDOG_W-1:0] stall_run;

    // Consecutive-stall counter with saturation; error sets on the cycle the count reaches the limit.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_run <= '0;
            wdog_err  <= 1'b0;
        end else begin
            if (!stall) begin
                stall_run <= '0;
            end else if (stall_run != LIMIT) begin
                stall_run <= stall_run + 1'b1;
            end
            if (stall && stall_run == LIMIT_M) begin
                wdog_err <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush controller: arbitrates exception, MDU stall, load-use stall
// and taken branch into per-stage write/flush enables (Mealy, same-cycle effect).
// Optional macro STALL_PERF_CNT_EN adds load-use / MDU stall-cycle counters.
module pipe_stall_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int EXC_FLUSH_CYC = 2,
    parameter int WDOG_W        = 8,
    parameter int WDOG_LIMIT    = 200
) (
    input  logic              clock,
    input  logic              reset,
    pipe_stall_ctrl_if.slave  bus
);

    localparam int DRAIN_W = (EXC_FLUSH_CYC > 1) ? $clog2(EXC_FLUSH_CYC) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_RELOAD = DRAIN_W'(EXC_FLUSH_CYC - 1);

    state_t             state, state_nxt;
    logic [DRAIN_W-1:0] drain_cnt, drain_nxt;
    ctrl_t              ctrl, ctrl_out;
    logic               lu_sel, mdu_sel;

    // Priority arbitration: exception > MDU stall > load-use stall > branch; also picks next state.
    always_comb begin
        ctrl      = CTRL_IDLE;
        state_nxt = RUN;
        drain_nxt = drain_cnt;
        lu_sel    = 1'b0;
        mdu_sel   = 1'b0;
        if (bus.exc_req) begin
            ctrl = CTRL_EXC;
            if (EXC_FLUSH_CYC > 1) begin
                state_nxt = EXC_DRAIN;
                drain_nxt = DRAIN_RELOAD;
            end
        end else if (state == EXC_DRAIN) begin
            ctrl = CTRL_DRAIN;
            if (drain_cnt > DRAIN_W'(1)) begin
                state_nxt = EXC_DRAIN;
                drain_nxt = drain_cnt - DRAIN_W'(1);
            end else begin
                drain_nxt = '0;
            end
        end else if (bus.mdu_busy && (state == MDU_WAIT || bus.mdu_use)) begin
            ctrl      = CTRL_STALL;
            mdu_sel   = 1'b1;
            state_nxt = MDU_WAIT;
        end else if (bus.lu_stall_req) begin
            ctrl   = CTRL_STALL;
            lu_sel = 1'b1;
        end else if (bus.branch_taken) begin
            ctrl = CTRL_BRANCH;
        end
    end

    // State and drain counter registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= RUN;
            drain_cnt <= '0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= drain_nxt;
        end
    end

    // While reset is held the pipeline is frozen and fully flushed.
    assign ctrl_out         = reset ? ctrl : CTRL_RST;
    assign bus.pc_write     = ctrl_out.pc_write;
    assign bus.if_id_write  = ctrl_out.if_id_write;
    assign bus.if_id_flush  = ctrl_out.if_id_flush;
    assign bus.id_ex_flush  = ctrl_out.id_ex_flush;
    assign bus.ex_mem_flush = ctrl_out.ex_mem_flush;

    stall_wdog #(
        .WDOG_W     (WDOG_W),
        .WDOG_LIMIT (WDOG_LIMIT)
    ) u_wdog (
        .clock    (clock),
        .reset    (reset),
        .stall    (!ctrl_out.pc_write),
        .wdog_err (bus.wdog_err)
    );

`ifdef STALL_PERF_CNT_EN
    logic [CNT_W-1:0] lu_cnt, mdu_cnt;

    // Stall-cycle performance counters, free-running with natural wrap.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lu_cnt  <= '0;
            mdu_cnt <= '0;
        end else begin
            if (lu_sel)  lu_cnt  <= lu_cnt + 1'b1;
            if (mdu_sel) mdu_cnt <= mdu_cnt + 1'b1;
        end
    end

    assign bus.lu_stall_cnt  = lu_cnt;
    assign bus.mdu_stall_cnt = mdu_cnt;
`else
    logic unused_sel;
    assign unused_sel        = lu_sel ^ mdu_sel;
    assign bus.lu_stall_cnt  = '0;
    assign bus.mdu_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl: directed scenarios plus randomized
// traffic, all compared against a cycle-level behavioural model.
module tb_pipe_stall_ctrl;
    import pipe_ctrl_pkg::*;

    localparam int EXC_CYC = 2;
    localparam int LIMIT   = 200;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    pipe_stall_ctrl_if bus ();

    pipe_stall_ctrl #(
        .EXC_FLUSH_CYC (EXC_CYC),
        .WDOG_W        (8),
        .WDOG_LIMIT    (LIMIT)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    int nvec = 0;
    int nerr = 0;

    // behavioural model state
    bit          m_hold;
    int          m_drain;
    int          m_run;
    bit          m_wdog;
    logic [31:0] m_lu_n;
    logic [31:0] m_mdu_n;
    logic [4:0]  exp_vec;
    bit          exp_lu, exp_mdu;

    wire [4:0] dut_vec = {bus.pc_write, bus.if_id_write, bus.if_id_flush,
                          bus.id_ex_flush, bus.ex_mem_flush};

    task automatic model_reset();
        m_hold = 0; m_drain = 0; m_run = 0; m_wdog = 0;
        m_lu_n = '0; m_mdu_n = '0;
    endtask

    task automatic model_eval();
        exp_lu = 0; exp_mdu = 0;
        if (bus.exc_req)                                        exp_vec = 5'b11111;
        else if (m_drain > 0)                                   exp_vec = 5'b11010;
        else if (bus.mdu_busy && (m_hold || bus.mdu_use)) begin exp_vec = 5'b00010; exp_mdu = 1; end
        else if (bus.lu_stall_req) begin                        exp_vec = 5'b00010; exp_lu = 1; end
        else if (bus.branch_taken)                              exp_vec = 5'b11100;
        else                                                    exp_vec = 5'b11000;
    endtask

    task automatic model_step();
        if (exp_vec[4]) m_run = 0;
        else if (m_run < LIMIT) m_run++;
        if (m_run == LIMIT) m_wdog = 1;
        if (bus.exc_req) begin
            m_drain = EXC_CYC - 1;
            m_hold  = 0;
        end else if (m_drain > 0) begin
            m_drain--;
        end else begin
            m_hold = exp_mdu;
        end
`ifdef STALL_PERF_CNT_EN
        if (exp_lu)  m_lu_n++;
        if (exp_mdu) m_mdu_n++;
`endif
    endtask

    task automatic apply(input bit lu, input bit use_, input bit busy, input bit br, input bit exc);
        @(negedge clock);
        bus.lu_stall_req = lu;
        bus.mdu_use      = use_;
        bus.mdu_busy     = busy;
        bus.branch_taken = br;
        bus.exc_req      = exc;
        #2;
        model_eval();
    endtask

    task automatic test_reset();
        bus.lu_stall_req = 0; bus.mdu_use = 0; bus.mdu_busy = 0;
        bus.branch_taken = 0; bus.exc_req = 0;
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clock); #2;
            nvec++;
            if ({dut_vec, bus.wdog_err, bus.lu_stall_cnt, bus.mdu_stall_cnt} !== {5'b00111, 1'b0, 64'h0}) begin
                nerr++;
                $display("FAIL reset_hold cyc=%0d got vec=%b wdog=%b lu=%0d mdu=%0d want vec=00111 wdog=0 cnt=0",
                         i, dut_vec, bus.wdog_err, bus.lu_stall_cnt, bus.mdu_stall_cnt);
            end
        end
        @(posedge clock); #1 reset = 1'b1;
        apply(0, 0, 0, 0, 0);
        nvec++;
        if (dut_vec !== 5'b11000) begin
            nerr++;
            $display("FAIL reset_release got vec=%b want 11000", dut_vec);
        end
        @(posedge clock); model_step();
    endtask

    task automatic run_seq(input string name, input logic [4:0] seq[$]);
        foreach (seq[k]) begin
            apply(seq[k][4], seq[k][3], seq[k][2], seq[k][1], seq[k][0]);
            nvec++;
            if ({dut_vec, bus.wdog_err, bus.lu_stall_cnt, bus.mdu_stall_cnt} !== {exp_vec, m_wdog, m_lu_n, m_mdu_n}) begin
                nerr++;
                $display("FAIL %s step=%0d got vec=%b wdog=%b lu=%0d mdu=%0d want vec=%b wdog=%b lu=%0d mdu=%0d",
                         name, k, dut_vec, bus.wdog_err, bus.lu_stall_cnt, bus.mdu_stall_cnt,
                         exp_vec, m_wdog, m_lu_n, m_mdu_n);
            end
            @(posedge clock); model_step();
        end
    endtask

    // stimulus encoding per step: {lu, mdu_use, mdu_busy, branch, exc}
    task automatic test_lu_stall();
        logic [4:0] s[$];
        s = '{5'b10000, 5'b00000, 5'b10000, 5'b10000, 5'b00000};
        run_seq("lu_stall", s);
    endtask

    task automatic test_mdu_stall();
        logic [4:0] s[$];
        logic [31:0] want;
        s = '{5'b01100, 5'b01100, 5'b00100, 5'b01100, 5'b00100, 5'b00000};
        run_seq("mdu_stall", s);
`ifdef STALL_PERF_CNT_EN
        want = 32'd5;
`else
        want = 32'd0;
`endif
        nvec++;
        if (bus.mdu_stall_cnt !== want) begin
            nerr++;
            $display("FAIL mdu_stall_cnt got %0d want %0d", bus.mdu_stall_cnt, want);
        end
    endtask

    task automatic test_exc_in_mdu();
        logic [4:0] s[$];
        s = '{5'b01100, 5'b01100, 5'b01101, 5'b11110, 5'b00100, 5'b00000,
              5'b00001, 5'b00001, 5'b10010, 5'b00000};
        run_seq("exc_in_mdu", s);
    endtask

    task automatic test_lu_branch();
        logic [4:0] s[$];
        s = '{5'b10010, 5'b00010, 5'b10010, 5'b00000};
        run_seq("lu_branch", s);
    endtask

    task automatic test_random(input int n);
        logic [4:0] s[$];
        for (int i = 0; i < n; i++) begin
            s.push_back({($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
                         1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                         ($urandom_range(0, 19) == 0)});
        end
        run_seq("random", s);
    endtask

    task automatic test_wdog();
        logic [4:0] s[$];
        for (int i = 0; i < LIMIT + 5; i++) s.push_back(5'b01100);
        run_seq("wdog_stall", s);
        nvec++;
        if (bus.wdog_err !== 1'b1) begin
            nerr++;
            $display("FAIL wdog_set got %b want 1", bus.wdog_err);
        end
        s = '{5'b00000, 5'b10000, 5'b00000, 5'b00000};
        run_seq("wdog_sticky", s);
    endtask

    task automatic test_async_reset();
        logic [4:0] s[$];
        s = '{5'b01100, 5'b01100};
        run_seq("pre_reset_stall", s);
        @(negedge clock); #2;
        reset = 1'b0;
        #1;
        nvec++;
        if ({dut_vec, bus.wdog_err, bus.lu_stall_cnt, bus.mdu_stall_cnt} !== {5'b00111, 1'b0, 64'h0}) begin
            nerr++;
            $display("FAIL async_reset got vec=%b wdog=%b lu=%0d mdu=%0d want vec=00111 wdog=0 cnt=0",
                     dut_vec, bus.wdog_err, bus.lu_stall_cnt, bus.mdu_stall_cnt);
        end
        model_reset();
        @(posedge clock); #1 reset = 1'b1;
        s = '{5'b00100, 5'b00000, 5'b10000, 5'b00000};
        run_seq("post_reset", s);
    endtask

    initial begin
        test_reset();
        test_lu_stall();
        test_mdu_stall();
        test_exc_in_mdu();
        test_lu_branch();
        test_random(400);
        test_wdog();
        test_async_reset();
        test_random(300);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1);
    end

endmodule
